// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock, releases sys_rst_n.
// Optional retry limit with a terminal FAIL state under `PLL_RETRY_LIMIT_EN.
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 17
`ifdef PLL_RETRY_LIMIT_EN
   ,
   parameter int MAX_RETRIES   = 4
`endif
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [2:0] state,
   output logic [7:0] lock_loss_cnt,
   output logic       timeout_err
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
`ifdef PLL_RETRY_LIMIT_EN
      RUN       = 3'd3,
      FAIL      = 3'd4
`else
      RUN       = 3'd3
`endif
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
`ifdef PLL_RETRY_LIMIT_EN
   localparam logic [2:0] RETRY_LAST = 3'(MAX_RETRIES - 1);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [7:0]       lock_loss_q, lock_loss_d;
   logic             timeout_q, timeout_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q, ready_d;
`ifdef PLL_RETRY_LIMIT_EN
   logic [2:0]       retry_q, retry_d;
`endif
   logic             locked_s;

   assign locked_s = sync2_q;

   always_comb begin
      sync1_d     = pll_locked;
      sync2_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_ONE;
      lock_loss_d = lock_loss_q;
      timeout_d   = timeout_q;
`ifdef PLL_RETRY_LIMIT_EN
      retry_d     = retry_q;
`endif
      unique case (state_q)
         RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         WAIT_LOCK: begin
            // Lock has priority over a timeout in the same cycle.
            if (locked_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = RESET_PLL;
`ifdef PLL_RETRY_LIMIT_EN
               if (retry_q == RETRY_LAST) begin
                  state_d = FAIL;
               end else begin
                  retry_d = retry_q + 3'd1;
               end
`endif
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == ST_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = '0;
`ifdef PLL_RETRY_LIMIT_EN
            retry_d = '0;
`endif
            if (!locked_s) begin
               state_d = RESET_PLL;
               if (lock_loss_q != 8'hFF) begin
                  lock_loss_d = lock_loss_q + 8'd1;
               end
            end
         end
`ifdef PLL_RETRY_LIMIT_EN
         FAIL: begin
            cnt_d = '0;
         end
`endif
         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase
      // Outputs decode the next state so they are registered with it.
      pll_rst_d   = (state_d != WAIT_LOCK) && (state_d != STABLE) &&
                    (state_d != RUN);
      sys_rst_n_d = (state_d == RUN);
      ready_d     = (state_d == RUN);
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         state_q     <= RESET_PLL;
         cnt_q       <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         lock_loss_q <= '0;
         timeout_q   <= 1'b0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
         retry_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         lock_loss_q <= lock_loss_d;
         timeout_q   <= timeout_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
`ifdef PLL_RETRY_LIMIT_EN
         retry_q     <= retry_d;
`endif
      end
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst_n     = sys_rst_n_q;
   assign ready         = ready_q;
   assign state         = state_q;
   assign lock_loss_cnt = lock_loss_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timed expectations from a scoreboard queue.
// Build with +define+PLL_RETRY_LIMIT_EN to exercise the FAIL state.
module tb_pll_lock_supervisor;

   typedef struct packed {
      logic [2:0] st;
      logic       prst;
      logic       srn;
      logic       rdy;
      logic       terr;
      logic [7:0] llc;
   } obs_t;

   typedef struct {
      int    t;
      string name;
      obs_t  v;
   } exp_t;

   logic       refclk;
   logic       rst;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       ready;
   logic [2:0] state;
   logic [7:0] lock_loss_cnt;
   logic       timeout_err;

   exp_t sb[$];
   int   t;
   int   n_chk;
   int   n_pass;

   pll_lock_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (100),
      .STABLE_CYCLES (10),
      .CNT_W         (17)
`ifdef PLL_RETRY_LIMIT_EN
      ,
      .MAX_RETRIES   (2)
`endif
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .pll_rst       (pll_rst),
      .sys_rst_n     (sys_rst_n),
      .ready         (ready),
      .state         (state),
      .lock_loss_cnt (lock_loss_cnt),
      .timeout_err   (timeout_err)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   function automatic obs_t mk(int st, bit pr, bit sr, bit rd, bit te,
                               int llc);
      obs_t o;
      o.st   = 3'(st);
      o.prst = pr;
      o.srn  = sr;
      o.rdy  = rd;
      o.terr = te;
      o.llc  = 8'(llc);
      return o;
   endfunction

   function automatic obs_t sample();
      return {state, pll_rst, sys_rst_n, ready, timeout_err, lock_loss_cnt};
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("st=%0d pll_rst=%b sys_rst_n=%b ready=%b terr=%b llc=%0d",
                       o.st, o.prst, o.srn, o.rdy, o.terr, o.llc);
   endfunction

   task automatic push(int when, string name, obs_t v);
      exp_t e;
      e.t    = when;
      e.name = name;
      e.v    = v;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
      t++;
   endtask

   // Release happens 1 time unit after an edge; t counts edges from there.
   task automatic do_reset(bit lk);
      rst        = 1'b0;
      pll_locked = lk;
      repeat (2) @(posedge refclk);
      #1;
      rst = 1'b1;
      t   = 0;
   endtask

   task automatic test_reset();
      obs_t o;
      obs_t w;
      rst        = 1'b0;
      pll_locked = 1'b1;
      repeat (3) @(posedge refclk);
      #1;
      o = sample();
      w = mk(0, 1, 0, 0, 0, 0);
      n_chk++;
      if (o !== w) $display("FAIL reset_held got %s want %s", fmt(o), fmt(w));
      else n_pass++;
      do_reset(0);
      o = sample();
      n_chk++;
      if (o !== w) $display("FAIL reset_release got %s want %s", fmt(o), fmt(w));
      else n_pass++;
   endtask

   task automatic test_nominal();
      exp_t e;
      obs_t o;
      do_reset(0);
      push(1,  "nom_prst1",  mk(0, 1, 0, 0, 0, 0));
      push(3,  "nom_prst3",  mk(0, 1, 0, 0, 0, 0));
      push(4,  "nom_wait",   mk(1, 0, 0, 0, 0, 0));
      push(26, "nom_wait26", mk(1, 0, 0, 0, 0, 0));
      push(27, "nom_stable", mk(2, 0, 0, 0, 0, 0));
      push(36, "nom_stab36", mk(2, 0, 0, 0, 0, 0));
      push(37, "nom_run",    mk(3, 0, 1, 1, 0, 0));
      push(45, "nom_run45",  mk(3, 0, 1, 1, 0, 0));
      while (t < 45) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
         if (t == 24) pll_locked = 1'b1;
      end
   endtask

   task automatic test_unstable();
      exp_t e;
      obs_t o;
      do_reset(0);
      push(13, "uns_stable",  mk(2, 0, 0, 0, 0, 0));
      push(17, "uns_stab17",  mk(2, 0, 0, 0, 0, 0));
      push(18, "uns_abort",   mk(1, 0, 0, 0, 0, 0));
      push(20, "uns_wait20",  mk(1, 0, 0, 0, 0, 0));
      push(21, "uns_restab",  mk(2, 0, 0, 0, 0, 0));
      push(30, "uns_stab30",  mk(2, 0, 0, 0, 0, 0));
      push(31, "uns_run",     mk(3, 0, 1, 1, 0, 0));
      while (t < 35) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
         if (t == 10) pll_locked = 1'b1;
         if (t == 15) pll_locked = 1'b0;
         if (t == 18) pll_locked = 1'b1;
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      obs_t o;
      int   t_end;
      do_reset(0);
      push(103, "to_last_wait", mk(1, 0, 0, 0, 0, 0));
      push(104, "to_retry1",    mk(0, 1, 0, 0, 1, 0));
      push(107, "to_prst_end",  mk(0, 1, 0, 0, 1, 0));
      push(108, "to_wait2",     mk(1, 0, 0, 0, 1, 0));
      push(207, "to_last2",     mk(1, 0, 0, 0, 1, 0));
`ifdef PLL_RETRY_LIMIT_EN
      push(208, "lim_fail",     mk(4, 1, 0, 0, 1, 0));
      push(300, "lim_fail300",  mk(4, 1, 0, 0, 1, 0));
      push(420, "lim_fail420",  mk(4, 1, 0, 0, 1, 0));
      t_end = 420;
`else
      push(208, "to_retry2",    mk(0, 1, 0, 0, 1, 0));
      push(212, "to_wait3",     mk(1, 0, 0, 0, 1, 0));
      push(311, "to_last3",     mk(1, 0, 0, 0, 1, 0));
      push(312, "to_retry3",    mk(0, 1, 0, 0, 1, 0));
      push(316, "to_wait4",     mk(1, 0, 0, 0, 1, 0));
      t_end = 320;
`endif
      while (t < t_end) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
      end
`ifdef PLL_RETRY_LIMIT_EN
      rst = 1'b0;
      #1;
      o = sample();
      n_chk++;
      if (o !== mk(0, 1, 0, 0, 0, 0))
         $display("FAIL lim_exit got %s want %s", fmt(o), fmt(mk(0, 1, 0, 0, 0, 0)));
      else n_pass++;
`endif
   endtask

   task automatic test_lock_loss();
      exp_t e;
      obs_t o;
      int   d;
      int   len;
      int   prev;
      int   llc;
      do_reset(1);
      push(15, "ll_run0", mk(3, 0, 1, 1, 0, 0));
      while (t < 20) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
      end
      // Drops of 2..5 cycles; each must be caught and re-qualified.
      for (int i = 1; i <= 257; i++) begin
         d    = t;
         len  = 2 + (i % 4);
         prev = (i - 1 > 255) ? 255 : i - 1;
         llc  = (i > 255) ? 255 : i;
         push(d + 2,  "ll_pre",    mk(3, 0, 1, 1, 0, prev));
         push(d + 3,  "ll_loss",   mk(0, 1, 0, 0, 0, llc));
         push(d + 6,  "ll_prst",   mk(0, 1, 0, 0, 0, llc));
         push(d + 7,  "ll_wait",   mk(1, 0, 0, 0, 0, llc));
         push(d + 18, "ll_rerun",  mk(3, 0, 1, 1, 0, llc));
         pll_locked = 1'b0;
         while (t < d + 20) begin
            tick();
            while (sb.size() > 0 && sb[0].t == t) begin
               e = sb.pop_front();
               o = sample();
               n_chk++;
               if (o !== e.v)
                  $display("FAIL %s #%0d t=%0d got %s want %s",
                           e.name, i, t, fmt(o), fmt(e.v));
               else n_pass++;
            end
            if (t == d + len) pll_locked = 1'b1;
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      obs_t o;
      do_reset(1);
      push(15, "rm_run",    mk(3, 0, 1, 1, 0, 0));
      push(23, "rm_loss",   mk(0, 1, 0, 0, 0, 1));
      push(28, "rm_stable", mk(2, 0, 0, 0, 0, 1));
      push(34, "rm_cnt6",   mk(2, 0, 0, 0, 0, 1));
      while (t < 34) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
         if (t == 20) pll_locked = 1'b0;
         if (t == 25) pll_locked = 1'b1;
      end
      rst = 1'b0;
      #1;
      o = sample();
      n_chk++;
      if (o !== mk(0, 1, 0, 0, 0, 0))
         $display("FAIL rm_async got %s want %s", fmt(o), fmt(mk(0, 1, 0, 0, 0, 0)));
      else n_pass++;
      @(posedge refclk);
      #1;
      rst = 1'b1;
      t   = 0;
      push(3,  "rm_prst3",  mk(0, 1, 0, 0, 0, 0));
      push(4,  "rm_wait",   mk(1, 0, 0, 0, 0, 0));
      push(5,  "rm_stab",   mk(2, 0, 0, 0, 0, 0));
      push(14, "rm_stab14", mk(2, 0, 0, 0, 0, 0));
      push(15, "rm_rerun",  mk(3, 0, 1, 1, 0, 0));
      while (t < 16) begin
         tick();
         while (sb.size() > 0 && sb[0].t == t) begin
            e = sb.pop_front();
            o = sample();
            n_chk++;
            if (o !== e.v)
               $display("FAIL %s t=%0d got %s want %s", e.name, t, fmt(o), fmt(e.v));
            else n_pass++;
         end
      end
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      t          = 0;
      rst        = 1'b0;
      pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_unstable();
      test_timeout();
      test_lock_loss();
      test_reset_mid();
      n_chk++;
      if (sb.size() != 0)
         $display("FAIL sb_drain left=%0d want 0 (first %s at t=%0d)",
                  sb.size(), sb[0].name, sb[0].t);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequencer at the consumer end of the PLL wrapper's rst/locked interface, clocked by the PLL reference clock.
- Drives the PLL reset and watches the PLL `locked` output, which it treats as asynchronous.
- Qualifies lock over a stability window before releasing the synchronous system reset.
- Re-sequences the PLL on lock timeout or loss of lock, and reports status and counters.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before the PLL reset is retried (≥2).
- STABLE_CYCLES, 1024: consecutive cycles the synchronized lock must be high before release (≥1).
- CNT_W, 17: width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- MAX_RETRIES, 4: timeout retries allowed before FAIL (used only with the optional feature).

Ports:
- refclk, input, 1: sole clock, the PLL reference clock.
- rst, input, 1: asynchronous, active-low reset of this block.
- pll_locked, input, 1: PLL lock indication; asynchronous to refclk.
- pll_rst, output, 1: active-high reset to the PLL.
- sys_rst_n, output, 1: active-low system reset, synchronous to refclk.
- ready, output, 1: high only in RUN.
- state, output, 3: current FSM state code.
- lock_loss_cnt, output, 8: count of RUN→RESET_PLL lock losses; saturates at 255.
- timeout_err, output, 1: sticky flag, set on any WAIT_LOCK timeout.

Behaviour:
- Reset values while rst=0: state=RESET_PLL (0), pll_rst=1, sys_rst_n=0, ready=0, lock_loss_cnt=0, timeout_err=0, counter=0, retry count=0, both synchronizer flops=0.
- All outputs are registered. Clearing is asynchronous; release of rst is sampled on refclk.
- Lock synchronizer: `pll_locked` passes through a 2-flop synchronizer to give `locked_s`, adding 2 cycles of latency. Only `locked_s` is used.
- State codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET_PLL:
  - pll_rst=1, sys_rst_n=0, counter increments each cycle.
  - When counter=RST_CYCLES-1, go to WAIT_LOCK and clear the counter.
  - pll_rst is therefore high for exactly RST_CYCLES cycles per entry, counted after rst release.
- WAIT_LOCK:
  - pll_rst=0, counter increments.
  - If locked_s=1, go to STABLE and clear the counter. Lock wins over a simultaneous timeout.
  - Otherwise, when counter=LOCK_TIMEOUT-1: set timeout_err, increment the retry count, go to RESET_PLL.
- STABLE:
  - pll_rst=0, counter increments while locked_s=1.
  - If locked_s=0, go back to WAIT_LOCK with the counter cleared. The lock timeout restarts from 0.
  - When counter=STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - sys_rst_n=1 and ready=1 from the first cycle in RUN; the retry count clears.
  - If locked_s=0: next cycle go to RESET_PLL with sys_rst_n=0 and ready=0, and increment lock_loss_cnt (saturating).
  - sys_rst_n deasserts synchronously but asserts in the same edge as leaving RUN.
- Glitch rule: a lock drop shorter than one refclk period may be missed. A drop of 2 or more cycles must be acted on.
- Reset mid-operation: rst low in any state immediately forces the reset values. Counters and flags are not retained.
- Counter arithmetic is unsigned CNT_W-bit and never wraps in legal configurations.

Optional Feature:
- Macro PLL_RETRY_LIMIT_EN.
- Defined:
  - A timeout in WAIT_LOCK while retry count = MAX_RETRIES-1 goes to FAIL instead of RESET_PLL.
  - FAIL holds pll_rst=1, sys_rst_n=0, ready=0. It is left only via rst.
  - The retry count is 3 bits wide.
- Undefined:
  - The FAIL state, the retry counter and MAX_RETRIES are not implemented.
  - Timeouts retry forever; timeout_err is still set.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=10.
- Nominal bring-up: release rst; pll_locked rises 20 cycles after pll_rst falls. Required: pll_rst high for exactly 4 cycles, then sys_rst_n=1 and ready=1 at 20+2+10 cycles (±1 per registered stage, checked exactly against the model); timeout_err=0.
- Unstable lock: locked high 5 cycles, low 3, then steady high. Required: STABLE aborts to WAIT_LOCK; RUN is reached 10 cycles after the final qualified rise; no timeout.
- Timeout retry: locked held 0. Required: timeout_err set at cycle 100 of WAIT_LOCK, a new 4-cycle pll_rst pulse follows, and the sequence repeats.
- Loss of lock in RUN: drop locked for 5 cycles. Required: sys_rst_n=0 within 3 cycles, lock_loss_cnt=1, a new 4-cycle pll_rst pulse, then re-qualification. After 256 losses, lock_loss_cnt stays at 255.
- Reset mid-STABLE: assert rst for 1 cycle at count 6. Required: all outputs return to reset values immediately, and the full sequence restarts.
- With PLL_RETRY_LIMIT_EN and MAX_RETRIES=2, locked held 0. Required: FAIL (state=4) after the second timeout, with pll_rst held high indefinitely until rst.
